datapath_p2: RTL and testbench
==============================

DATAPATH_P2 -- requirements
Module: datapath_p2

Interface
REQ-001 SHALL have ports in order: outp, BranchMet, PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, IncPC, Read, Write, ALUovr, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe, Clock, Clear, Mdatain, InputDev, ALUop, MARout, Yout.
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Clear  in  1  reset, synchronous and active-low.
REQ-004 outp  out  32  OutPort register contents.
REQ-005 BranchMet  out  1  CON flip-flop.
REQ-006 PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, MARout, Yout  in  1 each  drive the named register onto the bus.
REQ-007 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONIn  in  1 each  load enables.
REQ-008 IncPC  in  1  ALU computes bus+1.
REQ-009 Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
REQ-010 Write  in  1  accepted and ignored; there is no internal memory.
REQ-011 Gra, Grb, Grc, Rin, Rout, BAout  in  1 each  register-file select/encode controls.
REQ-012 Cout  in  1  drive sign-extended IR[18:0] onto the bus.
REQ-013 Strobe  in  1  load InPort from InputDev.
REQ-014 Mdatain, InputDev  in  32 each  memory data and input device.
REQ-015 ALUovr  in  1, ALUop  in  5  when ALUovr = 1 the ALU uses ALUop instead of IR[31:27].

Function
REQ-016 Storage: R0-R15, PC, IR, MAR, MDR, Y, HI, LO, InPort, OutPort (all 32 bits); Z (64 bits); CON (1 bit).
REQ-017 Bus: one 32-bit mux with fixed priority R(Rout/BAout) > HI > LO > Zhi > Zlo > PC > MDR > InPort > C > MAR > Y; bus = 0 when no driver is asserted.
REQ-018 IR fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C2 IR[20:19].
REQ-019 Register select = Ra&Gra | Rb&Grb | Rc&Grc; the selected register loads the bus on Rin and drives the bus on Rout or BAout.
REQ-020 With BAout asserted and R0 selected, the bus value is 0.
REQ-021 MDR loads on MDRin: Read ? Mdatain : bus.
REQ-022 ALU operands: A = Y, B = bus; the combinational result loads into Z on Zin.
REQ-023 IncPC overrides the opcode: Zlow = B+1, Zhi = 0.
REQ-024 Opcode map (result in Zlow; Zhi = 0 unless stated):
  - 00000-00010, 00011, 01100, 10011: add
  - 00100: sub
  - 00101, 01101: and
  - 00110, 01110: or
  - 00111: ror
  - 01000: rol
  - 01001: shr
  - 01010: shra
  - 01011: shl
  - 01111: div (Zlo = quotient, Zhi = remainder; divide by 0 gives 0, 0)
  - 10000: signed mul (64-bit result across Zhi:Zlo)
  - 10001: neg B
  - 10010: not B
  - all others: pass B
REQ-025 Shift and rotate amount = A[4:0], applied to B; all arithmetic is 32-bit wrap-around.
REQ-026 CON loads on CONIn from the bus value evaluated against C2:
  - 00: ==0
  - 01: !=0
  - 10: >=0 (signed)
  - 11: <0 (signed)
REQ-027 InPort loads InputDev on Strobe; OutPort loads the bus on OutPortin; outp is continuously OutPort.
REQ-028 Simultaneous enables all load the same bus value in the same edge.

Reset
REQ-029 Clear = 0 at a rising edge SHALL zero every register, Z, CON, InPort and OutPort, so outp = 0 and BranchMet = 0.
REQ-030 Clear has priority over all load enables in the same cycle.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the C2 condition codes and the IR field positions.
REQ-032 A single sub-module, datapath_p2_alu (combinational, 64-bit result), SHALL implement the ALU; registers, bus and select/encode logic SHALL live in the top level.

Verification
REQ-033 Scenario, out R2:
  - Read = 1, MDRin = 1, Mdatain = 0x01000000; MDRout, IRin; then Mdatain = 10, MDRin; MDRout, Gra, Rin -> R2 = 10.
  - Fetch 0xB1000000 into IR; Gra, Rout, OutPortin -> outp = 10.
REQ-034 Scenario, fetch: PC = 0; PCout, MARin, IncPC, Zin; then Zlowout, PCin -> PC = 1, MAR = 0.
REQ-035 Scenario, signed mul: Y = 0xFFFFFFFE (-2), bus = 3, opcode 10000, Zin -> Zhi = 0xFFFFFFFF, Zlo = 0xFFFFFFFA.
REQ-036 Scenario, CON: IR C2 = 01, bus = 0, CONIn -> BranchMet = 0; bus = 5 -> BranchMet = 1.
REQ-037 Scenario, BAout: R0 = 7; Grb selects R0, BAout, Yin -> Y = 0; with Rout instead -> Y = 7.
REQ-038 Scenario, reset: outp = 10 and Clear = 0 for one edge -> outp = 0 and BranchMet = 0 on that edge, not before it.

Source files
------------

// File: rtl/datapath_p2_pkg.sv
// Shared constants for the datapath_p2 slice:
// ALU opcodes, CON condition codes and IR field positions.
package datapath_p2_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;

  typedef enum logic [1:0] {
    C2_EQZ = 2'b00,
    C2_NEZ = 2'b01,
    C2_GEZ = 2'b10,
    C2_LTZ = 2'b11
  } c2_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;
  localparam int C2_HI  = 20;
  localparam int C2_LO  = 19;
  localparam int CX_HI  = 18;

endpackage

// File: rtl/datapath_p2_alu.sv
// Combinational ALU: A = Y, B = bus; 64-bit result {Zhi, Zlo}.
module datapath_p2_alu
  import datapath_p2_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_op,
  input  logic        i_inc,
  output logic [63:0] o_res
);

  logic [4:0]  w_sh;
  logic [63:0] w_ror;
  logic [63:0] w_rol;
  logic [63:0] w_prod;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_sh   = i_a[4:0];
  assign w_ror  = {i_b, i_b} >> w_sh;
  assign w_rol  = {i_b, i_b} << w_sh;
  assign w_prod = $signed({{32{i_a[31]}}, i_a})
                * $signed({{32{i_b[31]}}, i_b});
  // divide by zero yields 0 quotient and 0 remainder
  assign w_q = (i_b == '0) ? '0 : $signed(i_a) / $signed(i_b);
  assign w_r = (i_b == '0) ? '0 : $signed(i_a) % $signed(i_b);

  always_comb begin
    o_res = {32'b0, i_b};
    if (i_inc) begin
      o_res = {32'b0, i_b + 32'd1};
    end else begin
      case (i_op)
        OP_LD, OP_LDI, OP_ST,
        OP_ADD, OP_ADDI, OP_BR:
          o_res = {32'b0, i_a + i_b};
        OP_SUB:  o_res = {32'b0, i_a - i_b};
        OP_AND,
        OP_ANDI: o_res = {32'b0, i_a & i_b};
        OP_OR,
        OP_ORI:  o_res = {32'b0, i_a | i_b};
        OP_ROR:  o_res = {32'b0, w_ror[31:0]};
        OP_ROL:  o_res = {32'b0, w_rol[63:32]};
        OP_SHR:  o_res = {32'b0, i_b >> w_sh};
        OP_SHRA: o_res = {32'b0, $signed(i_b) >>> w_sh};
        OP_SHL:  o_res = {32'b0, i_b << w_sh};
        OP_DIV:  o_res = {w_r, w_q};
        OP_MUL:  o_res = w_prod;
        OP_NEG:  o_res = {32'b0, 32'd0 - i_b};
        OP_NOT:  o_res = {32'b0, ~i_b};
        default: o_res = {32'b0, i_b};
      endcase
    end
  end

endmodule

// File: rtl/datapath_p2.sv
// Bus-based CPU datapath: register file, bus mux,
// select/encode logic, CON flip-flop and ALU wrapper.
module datapath_p2
  import datapath_p2_pkg::*;
(
  output logic [31:0] outp,
  output logic        BranchMet,
  input  logic        PCout,
  input  logic        Zhiout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        InPortout,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        OutPortin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic        ALUovr,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Cout,
  input  logic        CONIn,
  input  logic        Strobe,
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Mdatain,
  input  logic [31:0] InputDev,
  input  logic [4:0]  ALUop,
  input  logic        MARout,
  input  logic        Yout
);

  logic [31:0] r_gpr [16];
  logic [31:0] r_pc, r_ir, r_mar, r_mdr, r_y;
  logic [31:0] r_hi, r_lo, r_inport, r_outport;
  logic [63:0] r_z;
  logic        r_con;

  logic [3:0]  w_sel;
  logic [31:0] w_rval;
  logic [31:0] w_c;
  logic [31:0] w_bus;
  logic [4:0]  w_op;
  logic [63:0] w_alu;
  logic        w_cond;
  logic        w_unused;

  assign w_unused = Write;

  assign w_sel = (r_ir[RA_HI:RA_LO] & {4{Gra}})
               | (r_ir[RB_HI:RB_LO] & {4{Grb}})
               | (r_ir[RC_HI:RC_LO] & {4{Grc}});

  // BAout reads R0 as constant zero for base addressing
  assign w_rval = (BAout && w_sel == 4'd0) ? '0
                                           : r_gpr[w_sel];
  assign w_c = {{13{r_ir[CX_HI]}}, r_ir[CX_HI:0]};

  always_comb begin
    w_bus = '0;
    priority case (1'b1)
      Rout, BAout: w_bus = w_rval;
      HIout:       w_bus = r_hi;
      LOout:       w_bus = r_lo;
      Zhiout:      w_bus = r_z[63:32];
      Zlowout:     w_bus = r_z[31:0];
      PCout:       w_bus = r_pc;
      MDRout:      w_bus = r_mdr;
      InPortout:   w_bus = r_inport;
      Cout:        w_bus = w_c;
      MARout:      w_bus = r_mar;
      Yout:        w_bus = r_y;
      default:     w_bus = '0;
    endcase
  end

  assign w_op = ALUovr ? ALUop : r_ir[OPC_HI:OPC_LO];

  datapath_p2_alu u_alu (
    .i_a   (r_y),
    .i_b   (w_bus),
    .i_op  (w_op),
    .i_inc (IncPC),
    .o_res (w_alu)
  );

  always_comb begin
    w_cond = 1'b0;
    case (c2_e'(r_ir[C2_HI:C2_LO]))
      C2_EQZ:  w_cond = (w_bus == '0);
      C2_NEZ:  w_cond = (w_bus != '0);
      C2_GEZ:  w_cond = ~w_bus[31];
      C2_LTZ:  w_cond = w_bus[31];
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_pc      <= '0;
      r_ir      <= '0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_y       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_inport  <= '0;
      r_outport <= '0;
      r_z       <= '0;
      r_con     <= 1'b0;
    end else begin
      if (Rin)       r_gpr[w_sel] <= w_bus;
      if (PCin)      r_pc      <= w_bus;
      if (IRin)      r_ir      <= w_bus;
      if (MARin)     r_mar     <= w_bus;
      if (MDRin)     r_mdr     <= Read ? Mdatain : w_bus;
      if (Yin)       r_y       <= w_bus;
      if (HIin)      r_hi      <= w_bus;
      if (LOin)      r_lo      <= w_bus;
      if (Zin)       r_z       <= w_alu;
      if (Strobe)    r_inport  <= InputDev;
      if (OutPortin) r_outport <= w_bus;
      if (CONIn)     r_con     <= w_cond;
    end
  end

  assign outp      = r_outport;
  assign BranchMet = r_con;

endmodule

// File: tb/tb_datapath_p2.sv
// Directed scoreboard bench for datapath_p2; internal
// registers are observed by routing them to OutPort.
module tb_datapath_p2;

  logic [31:0] outp;
  logic        BranchMet;
  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout;
  logic InPortout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic HIin, LOin, OutPortin, IncPC, Read, Write;
  logic ALUovr, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic CONIn, Strobe, Clock, Clear, MARout, Yout;
  logic [31:0] Mdatain, InputDev;
  logic [4:0]  ALUop;

  typedef struct {
    string       tag;
    bit          bm;
    logic [31:0] v;
  } exp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  exp_t q[$];
  vec_t tv[17];
  int   checks = 0;
  int   errors = 0;

  datapath_p2 dut (
    .outp(outp), .BranchMet(BranchMet),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .InPortout(InPortout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .ALUovr(ALUovr), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .CONIn(CONIn), .Strobe(Strobe), .Clock(Clock),
    .Clear(Clear), .Mdatain(Mdatain), .InputDev(InputDev),
    .ALUop(ALUop), .MARout(MARout), .Yout(Yout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic idle();
    PCout = 0; Zhiout = 0; Zlowout = 0; MDRout = 0;
    HIout = 0; LOout = 0; InPortout = 0; MARin = 0;
    Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
    HIin = 0; LOin = 0; OutPortin = 0; IncPC = 0;
    Read = 0; Write = 0; ALUovr = 0; Gra = 0; Grb = 0;
    Grc = 0; Rin = 0; Rout = 0; BAout = 0; Cout = 0;
    CONIn = 0; Strobe = 0; MARout = 0; Yout = 0;
    ALUop = 5'b0; Clear = 1'b1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic push_exp(input string t, input bit bm,
                          input logic [31:0] v);
    exp_t e;
    e.tag = t; e.bm = bm; e.v = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = e.bm ? {31'b0, BranchMet} : outp;
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h",
               e.tag, obs, e.v);
      end
    end
  endtask

  // caller asserts the bus source before calling
  task automatic show(input string t, input logic [31:0] v);
    OutPortin = 1;
    push_exp(t, 0, v);
    tick();
    drain();
  endtask

  task automatic mdr_load(input logic [31:0] v);
    Read = 1; MDRin = 1; Mdatain = v;
    tick();
  endtask

  task automatic ir_load(input logic [31:0] v);
    mdr_load(v);
    MDRout = 1; IRin = 1;
    tick();
  endtask

  task automatic y_load(input logic [31:0] v);
    mdr_load(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  initial begin
    tv[0]  = '{5'b00011, 32'd5, 32'd7, 32'd12, 32'd0};
    tv[1]  = '{5'b00100, 32'd5, 32'd7, 32'hFFFFFFFE, 32'd0};
    tv[2]  = '{5'b00101, 32'hF0F0F0F0, 32'hFF00FF00,
               32'hF000F000, 32'd0};
    tv[3]  = '{5'b00110, 32'hF0F0F0F0, 32'h0F000000,
               32'hFFF0F0F0, 32'd0};
    tv[4]  = '{5'b00111, 32'd4, 32'h00000013,
               32'h30000001, 32'd0};
    tv[5]  = '{5'b01000, 32'd8, 32'h80000001,
               32'h00000180, 32'd0};
    tv[6]  = '{5'b01001, 32'd4, 32'h80000000,
               32'h08000000, 32'd0};
    tv[7]  = '{5'b01010, 32'd4, 32'h80000000,
               32'hF8000000, 32'd0};
    tv[8]  = '{5'b01011, 32'd31, 32'd3, 32'h80000000, 32'd0};
    tv[9]  = '{5'b01111, 32'd17, 32'd5, 32'd3, 32'd2};
    tv[10] = '{5'b01111, 32'd17, 32'd0, 32'd0, 32'd0};
    tv[11] = '{5'b10000, 32'hFFFFFFFE, 32'd3,
               32'hFFFFFFFA, 32'hFFFFFFFF};
    tv[12] = '{5'b10001, 32'd9, 32'd5, 32'hFFFFFFFB, 32'd0};
    tv[13] = '{5'b10010, 32'd9, 32'h0F0F0F0F,
               32'hF0F0F0F0, 32'd0};
    tv[14] = '{5'b11111, 32'd9, 32'h12345678,
               32'h12345678, 32'd0};
    tv[15] = '{5'b10011, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd0};
    tv[16] = '{5'b00111, 32'd0, 32'hDEADBEEF,
               32'hDEADBEEF, 32'd0};
  end

  initial begin
    idle();
    Mdatain = '0;
    InputDev = '0;
    #2;
    Clear = 0;
    push_exp("rst_outp", 0, 32'd0);
    push_exp("rst_bm", 1, 32'd0);
    tick();
    drain();

    // load R2 via MDR, then send it to OutPort
    mdr_load(32'h01000000);
    MDRout = 1; IRin = 1;
    tick();
    mdr_load(32'd10);
    MDRout = 1; Gra = 1; Rin = 1;
    tick();
    ir_load(32'hB1000000);
    Gra = 1; Rout = 1;
    show("out_r2", 32'd10);

    // fetch twice: PC 0 -> 1 -> 2
    for (int i = 0; i < 2; i++) begin
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
      tick();
      Zlowout = 1; PCin = 1;
      tick();
      MARout = 1;
      show($sformatf("fetch%0d_mar", i), 32'(i));
      PCout = 1;
      show($sformatf("fetch%0d_pc", i), 32'(i + 1));
    end

    for (int i = 0; i < 17; i++) begin
      y_load(tv[i].a);
      mdr_load(tv[i].b);
      MDRout = 1; ALUovr = 1; ALUop = tv[i].op; Zin = 1;
      tick();
      Zlowout = 1;
      show($sformatf("alu%0d_lo", i), tv[i].lo);
      Zhiout = 1;
      show($sformatf("alu%0d_hi", i), tv[i].hi);
    end

    // CON with C2 = 01 (!=0); bus idle is zero
    ir_load(32'h00080000);
    CONIn = 1;
    push_exp("con_nez_0", 1, 32'd0);
    tick();
    drain();
    mdr_load(32'd5);
    MDRout = 1; CONIn = 1;
    push_exp("con_nez_5", 1, 32'd1);
    tick();
    drain();

    // CON with C2 = 11 (<0 signed)
    ir_load(32'h00180000);
    mdr_load(32'd5);
    MDRout = 1; CONIn = 1;
    push_exp("con_ltz_5", 1, 32'd0);
    tick();
    drain();
    mdr_load(32'h80000000);
    MDRout = 1; CONIn = 1;
    push_exp("con_ltz_neg", 1, 32'd1);
    tick();
    drain();

    // sign-extended constant from IR[18:0]
    ir_load(32'h00040005);
    Cout = 1;
    show("cout_sext", 32'hFFFC0005);

    // InPort strobe
    InputDev = 32'hCAFEF00D;
    Strobe = 1;
    tick();
    InPortout = 1;
    show("inport", 32'hCAFEF00D);

    // simultaneous HI/LO load
    mdr_load(32'h00C0FFEE);
    MDRout = 1; HIin = 1; LOin = 1;
    tick();
    HIout = 1;
    show("hi", 32'h00C0FFEE);
    LOout = 1;
    show("lo", 32'h00C0FFEE);

    // BAout on R0 reads zero, Rout reads R0
    ir_load(32'h00000000);
    mdr_load(32'd7);
    MDRout = 1; Gra = 1; Rin = 1;
    tick();
    Grb = 1; BAout = 1; Yin = 1;
    tick();
    Yout = 1;
    show("baout_r0", 32'd0);
    Grb = 1; Rout = 1; Yin = 1;
    tick();
    Yout = 1;
    show("rout_r0", 32'd7);
    mdr_load(32'h55555555);
    Gra = 1; Rout = 1; MDRout = 1;
    show("bus_prio", 32'd7);

    // reset takes effect on the edge, not before
    mdr_load(32'd10);
    MDRout = 1;
    show("pre_rst", 32'd10);
    Clear = 0; MDRout = 1; OutPortin = 1;
    #1;
    push_exp("rst_hold_outp", 0, 32'd10);
    push_exp("rst_hold_bm", 1, 32'd1);
    drain();
    push_exp("rst2_outp", 0, 32'd0);
    push_exp("rst2_bm", 1, 32'd0);
    tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
